// File: rtl/keccak_pkg.sv
// keccak_pkg: shared squeeze FSM state type and default SHA3-256 geometry.
package keccak_pkg;
  localparam int DEF_RATE_W = 1088;
  localparam int DEF_WORD_W = 64;
  typedef enum logic [1:0] {IDLE, WAIT_BLK, EMIT} sq_state_t;
endpackage

// File: rtl/keccak_piso_buf.sv
// keccak_piso_buf: parallel-load rate buffer that shifts out one word at a time.
module keccak_piso_buf
  import keccak_pkg::*;
#(
  parameter int RATE_W = DEF_RATE_W,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [RATE_W-1:0] din,
  output logic [WORD_W-1:0] dout
);
  logic [RATE_W-1:0] sr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else if (load) sr <= din;
    else if (shift) sr <= sr >> WORD_W;
  assign dout = sr[WORD_W-1:0];
endmodule

// File: rtl/keccak_squeeze_out.sv
// keccak_squeeze_out: streams len_words words out of successive rate blocks,
// requesting a new permutation each time a block is exhausted.
module keccak_squeeze_out
  import keccak_pkg::*;
#(
  parameter int RATE_W = DEF_RATE_W,
  parameter int WORD_W = DEF_WORD_W,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len_words,
  input  logic              blk_valid,
  input  logic [RATE_W-1:0] blk_data,
  output logic              blk_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              perm_req,
  output logic              busy,
  output logic              done
);
  localparam int NW = RATE_W / WORD_W;
  localparam int IDX_W = NW > 1 ? $clog2(NW) : 1;
  if (RATE_W % WORD_W != 0) begin : g_bad_geom
    $error("RATE_W must be a multiple of WORD_W");
  end
  sq_state_t        state;
  logic [LEN_W-1:0] rem;
  logic [IDX_W-1:0] idx;
  logic [WORD_W-1:0] buf_lo;
  logic             hs;
  assign blk_ready = state == WAIT_BLK;
  assign out_valid = state == EMIT;
  assign busy      = state != IDLE;
  assign out_last  = out_valid && rem == LEN_W'(1);
  assign out_data  = out_valid ? buf_lo : '0;
  assign hs        = out_valid && out_ready;
  keccak_piso_buf #(.RATE_W(RATE_W), .WORD_W(WORD_W)) u_buf (
    .clk(clk), .rst_n(rst_n), .load(blk_ready && blk_valid), .shift(hs),
    .din(blk_data), .dout(buf_lo)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      rem      <= '0;
      idx      <= '0;
      perm_req <= 1'b0;
      done     <= 1'b0;
    end else begin
      perm_req <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE:
          if (start && len_words != '0) begin
            state <= WAIT_BLK;
            rem   <= len_words;
          end else if (start) done <= 1'b1;
        WAIT_BLK:
          if (blk_valid) begin
            state <= EMIT;
            idx   <= '0;
          end
        EMIT:
          if (out_ready) begin
            rem <= rem - LEN_W'(1);
            idx <= idx + IDX_W'(1);
            if (rem == LEN_W'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end else if (idx == IDX_W'(NW - 1)) begin
              state    <= WAIT_BLK;
              perm_req <= 1'b1;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_keccak_squeeze_out.sv
// tb_keccak_squeeze_out: directed table plus hand sequences for wrap, stall, zero length and reset.
module tb_keccak_squeeze_out;
  localparam int RW = 1088, WW = 64, LW = 16, NW = 17;
  logic clk = 0, rst_n = 0, start = 0, blk_valid = 0, out_ready = 0;
  logic [LW-1:0] len_words = '0;
  logic [RW-1:0] blk_data = '0;
  logic blk_ready, out_valid, out_last, perm_req, busy, done;
  logic [WW-1:0] out_data;
  int n_cmp = 0, n_bad = 0;

  keccak_squeeze_out dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len_words(len_words),
    .blk_valid(blk_valid), .blk_data(blk_data), .blk_ready(blk_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .perm_req(perm_req), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic start; logic [LW-1:0] len; logic bv; logic ordy;
    logic br; logic ov; logic [WW-1:0] d; logic last; logic perm; logic busy; logic done;
  } rec_t;
  rec_t tv[7];

  function automatic logic [RW-1:0] mk_blk(input logic [WW-1:0] base);
    logic [RW-1:0] r;
    for (int i = 0; i < NW; i++) r[i*WW +: WW] = base + WW'(i);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic br, ov, input logic [WW-1:0] d,
                         input logic last, perm, bsy, dn);
    chk({nm, ".blk_ready"}, WW'(blk_ready), WW'(br));
    chk({nm, ".out_valid"}, WW'(out_valid), WW'(ov));
    chk({nm, ".out_data"}, out_data, d);
    chk({nm, ".out_last"}, WW'(out_last), WW'(last));
    chk({nm, ".perm_req"}, WW'(perm_req), WW'(perm));
    chk({nm, ".busy"}, WW'(busy), WW'(bsy));
    chk({nm, ".done"}, WW'(done), WW'(dn));
  endtask

  task automatic begin_squeeze(input logic [LW-1:0] n, input logic [RW-1:0] blk);
    start = 1; len_words = n;
    @(negedge clk);
    start = 0;
    chk("sq.blk_ready", WW'(blk_ready), 1);
    blk_valid = 1; blk_data = blk;
    @(negedge clk);
    blk_valid = 0;
  endtask

  initial begin
    tv[0] = '{1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    tv[1] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0};
    tv[2] = '{0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0};
    tv[3] = '{0, 0, 0, 1, 0, 1, 2, 0, 0, 1, 0};
    tv[4] = '{0, 0, 0, 1, 0, 1, 3, 1, 0, 1, 0};
    tv[5] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    tv[6] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    blk_data = mk_blk(1);
    repeat (2) @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1;
    @(negedge clk);

    // second pass injects start and blk_valid while emitting; result must not change
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 7; r++) begin
        chk_all($sformatf("tbl%0d.r%0d", p, r), tv[r].br, tv[r].ov, tv[r].d,
                tv[r].last, tv[r].perm, tv[r].busy, tv[r].done);
        start = tv[r].start | (p == 1 && tv[r].ov);
        len_words = tv[r].len;
        blk_valid = tv[r].bv | (p == 1 && tv[r].ov);
        out_ready = tv[r].ordy;
        @(negedge clk);
      end
    start = 0; blk_valid = 0;

    out_ready = 1;
    begin_squeeze(20, mk_blk(1));
    for (int i = 0; i < NW; i++) begin
      chk($sformatf("wrapA.w%0d", i), out_data, WW'(i + 1));
      chk($sformatf("wrapA.last%0d", i), WW'(out_last), 0);
      @(negedge clk);
    end
    chk_all("wrap.gap", 1, 0, 0, 0, 1, 1, 0);
    blk_valid = 1; blk_data = mk_blk(WW'(256));
    @(negedge clk);
    blk_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk_all($sformatf("wrapB.w%0d", i), 0, 1, WW'(256 + i), i == 2, 0, 1, 0);
      @(negedge clk);
    end
    chk_all("wrap.done", 0, 0, 0, 0, 0, 0, 1);

    begin
      logic [3:0] pat;
      int hs, dn;
      pat = 4'b1001;
      hs = 0; dn = 0;
      out_ready = 0;
      begin_squeeze(2, mk_blk(1));
      for (int i = 0; i < 4; i++) begin
        out_ready = pat[3 - i];
        chk($sformatf("stall.d%0d", i), out_data, i == 0 ? 1 : 2);
        chk($sformatf("stall.last%0d", i), WW'(out_last), WW'(i != 0));
        if (out_valid && out_ready) hs++;
        @(negedge clk);
      end
      out_ready = 1;
      for (int i = 0; i < 3; i++) begin
        if (out_valid && out_ready) hs++;
        if (done) dn++;
        @(negedge clk);
      end
      chk("stall.handshakes", WW'(hs), 2);
      chk("stall.done_count", WW'(dn), 1);
    end

    start = 1; len_words = 0;
    @(negedge clk);
    start = 0;
    chk_all("len0.c1", 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk_all("len0.c2", 0, 0, 0, 0, 0, 0, 0);

    out_ready = 1;
    begin_squeeze(17, mk_blk(1));
    repeat (4) @(negedge clk);
    chk("rst.pre_word", out_data, 5);
    #2 rst_n = 0;
    #1 chk_all("rst.async", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all($sformatf("rst.after%0d", i), 0, 0, 0, 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
